gemm_result_drain: RTL and testbench
====================================

# gemm_result_drain

Reads a finished M×N result matrix out of SRAM C (the 32-bit row-major buffer the GEMM accelerator writes) and streams it element by element over a valid/ready output port. Sits beside `gemm_accelerator_top` on the SRAM C side, owning the read port once `done_o` has fired. Provides full-rate readback under backpressure via a credit-limited 2-entry output FIFO.

## Interface

Parameters:
- `DataWidth`, 32, width of one C element.
- `AddrWidth`, 12, SRAM C address width.
- `SizeWidth`, 12, width of `M_size_i`/`N_size_i`.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  start pulse; sampled only in IDLE.
- `M_size_i`  in  SizeWidth  row count; sampled with `start_i`.
- `N_size_i`  in  SizeWidth  column count; sampled with `start_i`.
- `base_addr_i`  in  AddrWidth  address of element (0,0); sampled with `start_i`.
- `sram_c_req_o`  out  1  read request.
- `sram_c_addr_o`  out  AddrWidth  read address.
- `sram_c_rdata_i`  in  DataWidth  read data, valid the cycle after `sram_c_req_o`.
- `m_data_o`  out  DataWidth  output element.
- `m_valid_o`  out  1  output valid.
- `m_ready_i`  in  1  downstream ready.
- `m_eol_o`  out  1  element is last of its row (n = N-1).
- `m_last_o`  out  1  element is last of matrix.
- `busy_o`  out  1  high from accepted start until done.
- `done_o`  out  1  one-cycle pulse when transfer completes.

## Operation

- States: IDLE, RUN, DONE.
- IDLE: `start_i`=1 latches M, N, base; if M=0 or N=0 go to DONE (no output), else RUN. `start_i` outside IDLE ignored.
- RUN: issue reads at base+i, i = 0..M·N-1, row-major; track (m,n) counters for `m_eol_o`/`m_last_o` tags, which travel with the data through the FIFO.
- Issue rule: `sram_c_req_o`=1 iff reads remain and (fifo occupancy + in-flight reads) < 2, or a pop occurs this cycle. One read in flight max.
- Read data is pushed into the FIFO the cycle after the request; FIFO never overflows by construction.
- Pop on `m_valid_o && m_ready_i`. When the pop carries `m_last_o`, go to DONE.
- DONE: `done_o`=1 for exactly one cycle, `busy_o`=0, return to IDLE.
- Arithmetic: element count M·N computed at 2·SizeWidth bits; address = (base + i) mod 2^AddrWidth (wraps silently).
- `m_data_o`, `m_eol_o`, `m_last_o` hold stable while `m_valid_o`=1 and `m_ready_i`=0; `m_valid_o` never drops without a handshake.

## Timing

- Reset (sync, `rst_ni`=0 at a rising edge): state IDLE, FIFO emptied, in-flight read discarded; all outputs 0 (`sram_c_req_o`, `sram_c_addr_o`, `m_data_o`, `m_valid_o`, `m_eol_o`, `m_last_o`, `busy_o`, `done_o`). Reset mid-transfer aborts with no `done_o`.
- Start sampled at edge E0: `busy_o`=1 and first `sram_c_req_o` in cycle after E0; first `m_valid_o`=1 two cycles later (3 cycles after E0).
- With `m_ready_i` held 1: one element per cycle; M·N elements finish 2+M·N cycles after E0; `done_o` in the cycle after the last handshake.
- M=0 or N=0: `done_o` in the cycle after E0, no requests.
- Ready deasserted: at most 2 elements buffered; requests stop within one cycle; resume same cycle ready returns.

## Structure

- Package `gemm_drain_pkg`: state enum (IDLE/RUN/DONE), FIFO entry struct {data, eol, last}, FIFO depth constant 2.
- Sub-module `drain_fifo`: 2-entry register FIFO with push/pop/occupancy, flush on reset.
- Top holds FSM, counters, credit logic.

## Test plan

- M=2, N=3, base=0, C[i]=i+100, ready=1 -> data 100..105 consecutive cycles, `m_eol_o` on 102 and 105, `m_last_o` on 105, `done_o` one cycle later.
- M=4, N=4, ready random 50% -> 16 elements in order, no duplicates/drops, data stable while stalled, FIFO occupancy ≤ 2.
- M=0, N=5 -> no `sram_c_req_o`, no `m_valid_o`, `done_o` the cycle after start.
- base=4094, M=1, N=4 -> addresses 4094, 4095, 0, 1.
- `start_i` pulsed during RUN with M=9 -> ignored; original transfer completes unchanged.
- `rst_ni`=0 after 3 of 16 elements -> all outputs 0 next cycle, no `done_o`; fresh start M=1,N=1 returns one element with `m_last_o`=1.

Source files
------------

// File: rtl/gemm_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gemm_drain_pkg
// Brief    : Shared types and constants for the SRAM C result drain.
// Revision : 1.0 - initial release
// ============================================================================
package gemm_drain_pkg;

  localparam int unsigned c_FIFO_DEPTH   = 2;
  localparam int unsigned c_PTR_W        = $clog2(c_FIFO_DEPTH);
  localparam int unsigned c_DRAIN_DATA_W = 32;
  localparam int unsigned c_ENTRY_W      = c_DRAIN_DATA_W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } drain_state_e;

  // Row/matrix tags ride alongside the element so they leave in lockstep.
  typedef struct packed {
    logic [c_DRAIN_DATA_W-1:0] data;
    logic                      eol;
    logic                      last;
  } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/drain_fifo.sv
`default_nettype none
// ============================================================================
// Module   : drain_fifo
// Brief    : Two-entry register FIFO buffering drained elements with tags.
// Revision : 1.0 - initial release
// ============================================================================
module drain_fifo
  import gemm_drain_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [c_ENTRY_W-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [c_ENTRY_W-1:0] head_o,
  output logic                 valid_o,
  output logic [c_PTR_W:0]     count_o
);

  fifo_entry_t        r_mem [c_FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_pop  = pop_i && (r_count != '0);
  assign w_do_push = push_i && ((r_count != (c_PTR_W+1)'(c_FIFO_DEPTH)) || w_do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(c_FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= fifo_entry_t'(push_data_i);
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign valid_o = (r_count != '0);
  assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/gemm_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : gemm_result_drain
// Brief    : Streams a finished row-major M x N matrix out of SRAM C over a
//            valid/ready port with credit-limited read issue.
// Revision : 1.0 - initial release
// ============================================================================
module gemm_result_drain
  import gemm_drain_pkg::*;
#(
  parameter int unsigned DataWidth = c_DRAIN_DATA_W,
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned SizeWidth = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [SizeWidth-1:0] M_size_i,
  input  logic [SizeWidth-1:0] N_size_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  output logic                 sram_c_req_o,
  output logic [AddrWidth-1:0] sram_c_addr_o,
  input  logic [DataWidth-1:0] sram_c_rdata_i,
  output logic [DataWidth-1:0] m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 m_eol_o,
  output logic                 m_last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned c_CNT_W = 2 * SizeWidth;

  drain_state_e         r_state;
  drain_state_e         w_state_nxt;
  logic [SizeWidth-1:0] r_m_size;
  logic [SizeWidth-1:0] r_n_size;
  logic [SizeWidth-1:0] r_row;
  logic [SizeWidth-1:0] r_col;
  logic [AddrWidth-1:0] r_base;
  logic [c_CNT_W-1:0]   r_total;
  logic [c_CNT_W-1:0]   r_issue_cnt;
  logic                 r_inflight;
  logic                 r_inf_eol;
  logic                 r_inf_last;

  logic                 w_start;
  logic                 w_zero_size;
  logic                 w_reads_left;
  logic                 w_credit_ok;
  logic                 w_pop;
  logic                 w_req;
  logic                 w_issue_eol;
  logic                 w_issue_last;
  logic [c_PTR_W:0]     w_fifo_count;
  logic [c_PTR_W:0]     w_occupancy;
  logic                 w_fifo_valid;
  logic [c_ENTRY_W-1:0] w_head_raw;
  fifo_entry_t          w_head;
  fifo_entry_t          w_push_entry;

  assign w_start      = (r_state == S_IDLE) && start_i;
  assign w_zero_size  = (M_size_i == '0) || (N_size_i == '0);
  assign w_reads_left = (r_issue_cnt < r_total);
  assign w_pop        = w_fifo_valid && m_ready_i;

  // Buffered plus in-flight elements must never exceed the FIFO depth, so a
  // read may only be issued into a free slot or one being vacated right now.
  assign w_occupancy  = w_fifo_count + (c_PTR_W+1)'(r_inflight);
  assign w_credit_ok  = (w_occupancy < (c_PTR_W+1)'(c_FIFO_DEPTH));

  assign w_issue_eol  = (r_col == (r_n_size - SizeWidth'(1)));
  assign w_issue_last = w_issue_eol && (r_row == (r_m_size - SizeWidth'(1)));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = w_zero_size ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy_o = 1'b1;
        w_req  = w_reads_left && (w_credit_ok || w_pop);
        if (w_pop && w_head.last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_m_size    <= '0;
      r_n_size    <= '0;
      r_base      <= '0;
      r_total     <= '0;
      r_issue_cnt <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_inflight  <= 1'b0;
      r_inf_eol   <= 1'b0;
      r_inf_last  <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_inf_eol  <= w_issue_eol;
        r_inf_last <= w_issue_last;
      end
      if (w_start) begin
        r_m_size    <= M_size_i;
        r_n_size    <= N_size_i;
        r_base      <= base_addr_i;
        r_total     <= c_CNT_W'(M_size_i) * c_CNT_W'(N_size_i);
        r_issue_cnt <= '0;
        r_row       <= '0;
        r_col       <= '0;
      end else if (w_req) begin
        r_issue_cnt <= r_issue_cnt + c_CNT_W'(1);
        if (w_issue_eol) begin
          r_col <= '0;
          r_row <= r_row + SizeWidth'(1);
        end else begin
          r_col <= r_col + SizeWidth'(1);
        end
      end
    end
  end

  assign w_push_entry = '{data: c_DRAIN_DATA_W'(sram_c_rdata_i),
                          eol:  r_inf_eol,
                          last: r_inf_last};

  drain_fifo u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (r_inflight),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .head_o      (w_head_raw),
    .valid_o     (w_fifo_valid),
    .count_o     (w_fifo_count)
  );

  assign w_head = fifo_entry_t'(w_head_raw);

  // Address wraps modulo 2^AddrWidth; it is forced to zero when idle.
  assign sram_c_req_o  = w_req;
  assign sram_c_addr_o = w_req ? (r_base + AddrWidth'(r_issue_cnt)) : '0;

  assign m_valid_o = w_fifo_valid;
  assign m_data_o  = w_fifo_valid ? DataWidth'(w_head.data) : '0;
  assign m_eol_o   = w_fifo_valid && w_head.eol;
  assign m_last_o  = w_fifo_valid && w_head.last;

endmodule
`default_nettype wire

// File: tb/tb_gemm_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_result_drain
// Brief    : Scoreboard bench for gemm_result_drain with an SRAM C model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gemm_result_drain;

  typedef struct packed {
    logic [31:0] data;
    logic        eol;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] m_size;
  logic [11:0] n_size;
  logic [11:0] base;
  logic        sram_c_req_o;
  logic [11:0] sram_c_addr_o;
  logic [31:0] sram_c_rdata;
  logic [31:0] m_data_o;
  logic        m_valid_o;
  logic        ready;
  logic        m_eol_o;
  logic        m_last_o;
  logic        busy_o;
  logic        done_o;

  always #5 clk = ~clk;

  gemm_result_drain dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .M_size_i       (m_size),
    .N_size_i       (n_size),
    .base_addr_i    (base),
    .sram_c_req_o   (sram_c_req_o),
    .sram_c_addr_o  (sram_c_addr_o),
    .sram_c_rdata_i (sram_c_rdata),
    .m_data_o       (m_data_o),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (ready),
    .m_eol_o        (m_eol_o),
    .m_last_o       (m_last_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  // SRAM C model: C[a] = a + 100, one-cycle read latency.
  logic [31:0] mem [4096];
  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 32'(a) + 32'd100;
    sram_c_rdata = '0;
  end
  always @(posedge clk) begin
    if (sram_c_req_o) sram_c_rdata <= mem[sram_c_addr_o];
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_cnt   = 0;
  int          done_cnt = 0;
  exp_t        exp_q[$];
  logic [11:0] addr_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not expected or not seen", name);
  endtask

  // Monitor: pops the scoreboard on each handshake and each read request.
  int   outstanding = 0;
  bit   prev_stall  = 0;
  exp_t prev_out;
  logic mon_pop;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outstanding = 0;
        prev_stall  = 0;
      end else begin
        mon_pop = m_valid_o && ready;
        if (prev_stall) begin
          check("stall_valid_held", 64'(m_valid_o), 64'd1);
          check("stall_data_held", 64'({m_data_o, m_eol_o, m_last_o}), 64'(prev_out));
        end
        if (sram_c_req_o) begin
          check("credit_limit", 64'((outstanding - int'(mon_pop)) < 2), 64'd1);
          if (addr_q.size() == 0) fail_now("unexpected_req");
          else check("req_addr", 64'(sram_c_addr_o), 64'(addr_q.pop_front()));
        end
        if (mon_pop) begin
          hs_cnt++;
          if (exp_q.size() == 0) fail_now("unexpected_output");
          else begin
            mon_e = exp_q.pop_front();
            check("out_data", 64'(m_data_o), 64'(mon_e.data));
            check("out_eol",  64'(m_eol_o),  64'(mon_e.eol));
            check("out_last", 64'(m_last_o), 64'(mon_e.last));
          end
        end
        if (done_o) done_cnt++;
        outstanding += int'(sram_c_req_o) - int'(mon_pop);
        prev_stall = m_valid_o && !ready;
        prev_out   = '{m_data_o, m_eol_o, m_last_o};
      end
    end
  end

  task automatic push_exp(input logic [11:0] a, input logic [31:0] d, input logic eol, input logic last);
    addr_q.push_back(a);
    exp_q.push_back('{d, eol, last});
  endtask

  task automatic push_xfer(input int m, input int n, input int b);
    logic [11:0] a;
    for (int i = 0; i < m * n; i++) begin
      a = 12'((b + i) % 4096);
      push_exp(a, 32'(a) + 32'd100, (i % n) == n - 1, i == m * n - 1);
    end
  endtask

  task automatic start_xfer(input int m, input int n, input int b);
    @(posedge clk); #1;
    start  = 1'b1;
    m_size = 12'(m);
    n_size = 12'(n);
    base   = 12'(b);
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic run(input int max_cyc, input bit rnd, input int inject_k,
                     output int done_k, output int first_v, output bit saw_req,
                     output bit busy1, output bit req1);
    done_k = -1; first_v = -1; saw_req = 0; busy1 = 0; req1 = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        busy1 = busy_o;
        req1  = sram_c_req_o;
      end
      if (sram_c_req_o) saw_req = 1;
      if (m_valid_o && first_v < 0) first_v = k;
      if (done_o) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
      if (rnd) ready = 1'($urandom_range(0, 1));
      start = (k == inject_k);
      if (k == inject_k) begin
        m_size = 12'd9;
        n_size = 12'd9;
        base   = 12'd500;
      end
    end
    start = 1'b0;
  endtask

  task automatic finish_xfer(input string name, input int done_k, input int d0);
    if (done_k < 0) fail_now({name, "_done_timeout"});
    check({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    @(negedge clk);
    check({name, "_done_one_cycle"}, 64'(done_o), 64'd0);
    check({name, "_exp_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_addr_drained"}, 64'(addr_q.size()), 64'd0);
    @(posedge clk); #1;
    ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int done_k, first_v, d0, hs0;
    bit saw_req, busy1, req1;
    rst_n = 1'b0; start = 1'b0; ready = 1'b1;
    m_size = '0; n_size = '0; base = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({sram_c_req_o, sram_c_addr_o, m_data_o, m_valid_o,
                                m_eol_o, m_last_o, busy_o, done_o}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // M=2, N=3, base=0 at full rate
    push_exp(12'd0, 32'd100, 1'b0, 1'b0);
    push_exp(12'd1, 32'd101, 1'b0, 1'b0);
    push_exp(12'd2, 32'd102, 1'b1, 1'b0);
    push_exp(12'd3, 32'd103, 1'b0, 1'b0);
    push_exp(12'd4, 32'd104, 1'b0, 1'b0);
    push_exp(12'd5, 32'd105, 1'b1, 1'b1);
    d0 = done_cnt;
    start_xfer(2, 3, 0);
    run(100, 0, -1, done_k, first_v, saw_req, busy1, req1);
    check("t1_busy_cycle1", 64'(busy1), 64'd1);
    check("t1_req_cycle1", 64'(req1), 64'd1);
    check("t1_first_valid_cycle", 64'(first_v), 64'd3);
    check("t1_done_cycle", 64'(done_k), 64'd9);
    finish_xfer("t1", done_k, d0);

    // M=4, N=4 under random backpressure
    push_xfer(4, 4, 10);
    d0 = done_cnt;
    start_xfer(4, 4, 10);
    run(2000, 1, -1, done_k, first_v, saw_req, busy1, req1);
    finish_xfer("t2", done_k, d0);

    // M=0, N=5: nothing streamed
    d0 = done_cnt;
    start_xfer(0, 5, 0);
    run(50, 0, -1, done_k, first_v, saw_req, busy1, req1);
    check("t3_done_cycle", 64'(done_k), 64'd1);
    check("t3_no_req", 64'(saw_req), 64'd0);
    check("t3_no_valid", 64'(first_v), 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3_busy_low", 64'(busy1), 64'd0);
    finish_xfer("t3", done_k, d0);

    // Address wrap: base=4094, M=1, N=4
    push_exp(12'd4094, 32'd4194, 1'b0, 1'b0);
    push_exp(12'd4095, 32'd4195, 1'b0, 1'b0);
    push_exp(12'd0,    32'd100,  1'b0, 1'b0);
    push_exp(12'd1,    32'd101,  1'b1, 1'b1);
    d0 = done_cnt;
    start_xfer(1, 4, 4094);
    run(100, 0, -1, done_k, first_v, saw_req, busy1, req1);
    check("t4_done_cycle", 64'(done_k), 64'd7);
    finish_xfer("t4", done_k, d0);

    // start pulsed with M=9 mid-run must be ignored
    push_xfer(2, 3, 20);
    d0 = done_cnt;
    start_xfer(2, 3, 20);
    run(100, 0, 2, done_k, first_v, saw_req, busy1, req1);
    check("t5_done_cycle", 64'(done_k), 64'd9);
    finish_xfer("t5", done_k, d0);

    // Reset after three of sixteen elements, then a fresh 1x1 transfer
    push_xfer(4, 4, 0);
    d0  = done_cnt;
    hs0 = hs_cnt;
    start_xfer(4, 4, 0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (hs_cnt - hs0 >= 3) break;
    end
    check("t6_three_handshakes", 64'(hs_cnt - hs0 >= 3), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_reset_outputs", 64'({sram_c_req_o, sram_c_addr_o, m_data_o, m_valid_o,
                                   m_eol_o, m_last_o, busy_o, done_o}), 64'd0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_no_done_after_abort", 64'(done_cnt - d0), 64'd0);
    check("t6_idle_after_abort", 64'({busy_o, m_valid_o, sram_c_req_o}), 64'd0);
    push_exp(12'd7, 32'd107, 1'b1, 1'b1);
    d0 = done_cnt;
    start_xfer(1, 1, 7);
    run(100, 0, -1, done_k, first_v, saw_req, busy1, req1);
    check("t6_fresh_done_cycle", 64'(done_k), 64'd4);
    finish_xfer("t6", done_k, d0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
